mem_bus_if: RTL
===============

# mem_bus_if

Data-memory bus interface between `mem_ctrl` and the external data bus. It takes the single-cycle access request that `mem_ctrl` produces and runs it as a multi-cycle strobe/ready bus transaction with wait states. It stalls the pipeline while the transaction is in flight, registers the returned read word for `mem_ctrl`, and reports misaligned or timed-out accesses.

## Interface
Parameters:
- `TIMEOUT`, default 255: wait-state limit for an access, in cycles.
- `TO_WIDTH`, default 8: width of the timeout counter. The counter must be able to hold `TIMEOUT`.

Ports:
- `clk`  in  1  single clock. All state changes on the rising edge.
- `rst_`  in  1  asynchronous, active-low reset.
- `mem_op_as_`  in  1  access request from `mem_ctrl`, active-low.
- `rw`  in  1  `READ`/`WRITE` from `mem_ctrl`.
- `addr_to_mem`  in  30  word address.
- `wr_data`  in  32  store data.
- `miss_align`  in  1  misalignment flag from `mem_ctrl`.
- `flush`  in  1  pipeline flush. Blocks the start of a new access.
- `mem_data`  out  32  registered read word returned to `mem_ctrl`.
- `busy`  out  1  pipeline stall request.
- `bus_err`  out  1  one-cycle error pulse.
- `bus_as_`  out  1  bus address strobe, active-low.
- `bus_rw`  out  1  bus direction.
- `bus_addr`  out  30  bus word address.
- `bus_wr_data`  out  32  bus write data.
- `bus_rd_data`  in  32  bus read data.
- `bus_rdy_`  in  1  bus ready, active-low.

## Operation
States: IDLE, ACCESS, DONE.

IDLE:
- A request is `mem_op_as_ == 0`.
- Request with `flush == 0` and `miss_align == 0`:
  - latch `addr_to_mem`, `rw` and `wr_data` into `bus_addr`, `bus_rw` and `bus_wr_data`;
  - set `bus_as_ = 0`;
  - clear the timeout counter;
  - go to ACCESS.
- Request with `miss_align == 1` and `flush == 0`:
  - no bus access;
  - `bus_err` pulses next cycle;
  - go to DONE.
- Request with `flush == 1`: ignored, stay in IDLE.

ACCESS:
- Hold `bus_as_ = 0` and all latched bus outputs stable.
- If `bus_rdy_` is sampled 0:
  - for a read, capture `bus_rd_data` into `mem_data`;
  - for a write, `mem_data` is unchanged;
  - set `bus_as_ = 1`;
  - go to DONE.
- Else if the counter equals `TIMEOUT`:
  - set `bus_as_ = 1`;
  - set `mem_data = 0`;
  - `bus_err` pulses in the DONE cycle;
  - go to DONE.
- Else increment the counter.
- `bus_rdy_ == 0` in the same cycle as a timeout: ready wins, no error.

DONE:
- `busy = 0`; the pipeline advances at the end of this cycle.
- The request still present on `mem_op_as_` belongs to the completed access and is ignored.
- Unconditionally go to IDLE.

`flush` in ACCESS does not abort the access; the bus transaction always completes.

`busy`:
- combinational;
- 1 in IDLE when a request with `miss_align == 0` and `flush == 0` is present;
- 1 in ACCESS;
- 0 otherwise.

`mem_data` holds its value until the next completed read.

## Timing
- Reset (asynchronous, `rst_ == 0`) values:
  - state IDLE;
  - `bus_as_ = 1`, `bus_rw = READ`;
  - `bus_addr = 0`, `bus_wr_data = 0`;
  - `mem_data = 0`;
  - `bus_err = 0`, `busy = 0`;
  - counter 0.
- Reset mid-ACCESS: the strobe drops immediately and the access is lost.
- Zero wait states:
  - request seen in cycle 0;
  - `bus_as_` low in cycle 1, where `bus_rdy_ = 0` is sampled;
  - DONE in cycle 2, `mem_data` valid in cycle 2;
  - `busy` high in cycles 0–1.
- Each cycle of `bus_rdy_ = 1` adds one ACCESS cycle.
- Timeout: `bus_as_` is low for `TIMEOUT + 1` cycles, then DONE follows.
- Back-to-back accesses: the minimum period is 3 cycles (IDLE, ACCESS, DONE).
- Misaligned request:
  - `busy` is 0 throughout;
  - DONE is entered in cycle 1 with `bus_err = 1`;
  - `bus_as_` never asserts.
- `bus_err` is high only in the DONE cycle.

## Test plan
- Reset check: hold `rst_ = 0`, drive a request → `bus_as_ = 1`, `busy = 0`, `mem_data = 0`. Release reset → the request is serviced.
- Zero-wait read:
  - stimulus: addr `0x0000_0010`, `bus_rd_data = 0xDEAD_BEEF`, `bus_rdy_ = 0` in the first strobe cycle;
  - response: `bus_addr = 0x10`, `busy` high for 2 cycles, `mem_data = 0xDEAD_BEEF` in DONE.
- Write with 3 wait states:
  - stimulus: `wr_data = 0x1234_5678`;
  - response: `bus_as_` low for 4 cycles with `bus_wr_data`/`bus_addr` stable, `mem_data` unchanged, `busy` high for 5 cycles.
- Timeout with `TIMEOUT = 4` and `bus_rdy_` stuck at 1 → `bus_as_` low for 5 cycles, then `bus_err` pulses once and `mem_data = 0`.
- Misaligned request (`miss_align = 1`) → no strobe, `bus_err` pulse in the next cycle, `busy` never asserted.
- Flush and reset edge cases:
  - `flush` asserted in IDLE with a request → no access;
  - `flush` asserted during ACCESS → the access completes normally;
  - `rst_` pulsed mid-ACCESS → `bus_as_` returns to 1 asynchronously.

Source files
------------

// File: rtl/mem_bus_if.sv
// Data-memory bus interface: turns single-cycle mem_ctrl requests into strobe/ready bus
// transactions with wait states, a timeout, and a misalignment error path.
module mem_bus_if #(
    parameter int TIMEOUT  = 255,
    parameter int TO_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        mem_op_as_,
    input  logic        rw,
    input  logic [29:0] addr_to_mem,
    input  logic [31:0] wr_data,
    input  logic        miss_align,
    input  logic        flush,
    output logic [31:0] mem_data,
    output logic        busy,
    output logic        bus_err,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_
);

    localparam logic READ = 1'b1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]          state;
    logic [TO_WIDTH-1:0] to_cnt;
    logic                req;
    logic                start;
    logic                timed_out;

    assign req       = ~mem_op_as_ & ~flush;
    assign start     = (state == IDLE) && req && !miss_align;
    assign timed_out = (to_cnt == TO_WIDTH'(TIMEOUT));

    // Gated by rst_ so a request presented while reset is held never stalls the pipeline.
    assign busy = rst_ && (start || (state == ACCESS));

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state       <= IDLE;
            to_cnt      <= '0;
            mem_data    <= '0;
            bus_err     <= 1'b0;
            bus_as_     <= 1'b1;
            bus_rw      <= READ;
            bus_addr    <= '0;
            bus_wr_data <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bus_addr    <= addr_to_mem;
                        bus_rw      <= rw;
                        bus_wr_data <= wr_data;
                        bus_as_     <= 1'b0;
                        to_cnt      <= '0;
                        state       <= ACCESS;
                    end else if (req && miss_align) begin
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end
                end
                // Ready takes priority over a timeout landing in the same cycle.
                ACCESS: begin
                    if (!bus_rdy_) begin
                        if (bus_rw == READ) begin
                            mem_data <= bus_rd_data;
                        end
                        bus_as_ <= 1'b1;
                        state   <= DONE;
                    end else if (timed_out) begin
                        bus_as_  <= 1'b1;
                        mem_data <= '0;
                        bus_err  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        to_cnt <= to_cnt + {{(TO_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
